// File: rtl/dsram_like_responder_if.sv
// Data-SRAM-like request/response bus: address-phase handshake plus a separate
// one-cycle data response.
interface dsram_like_responder_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/dsram_like_responder.sv
// Word-addressed SRAM responder with a bounded, in-order response FIFO, a
// per-entry minimum response delay and a sticky protocol-violation flag.
module dsram_like_responder #(
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned MAX_OUT    = 2,
   parameter int unsigned RESP_DELAY = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   dsram_like_responder_if.slave  bus,
   output logic                   prot_err
);

   localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUT + 1);
   localparam logic [2:0]  DlyInit = 3'(RESP_DELAY - 1);

   logic [31:0]      mem [2**IDX_W];
   logic [31:0]      rd_q [MAX_OUT];
   logic [2:0]       dly_q [MAX_OUT];
   logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             prot_err_q;

   logic [IDX_W-1:0] idx;
   logic             push, pop, bad;
   logic [31:0]      rd_capture;
   logic             unused_addr_bits;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Upper address bits alias onto the same storage.
   assign idx              = bus.data_sram_addr[IDX_W+1:2];
   assign unused_addr_bits = ^bus.data_sram_addr[31:IDX_W+2];

   // Depends only on state and reset, never on req.
   assign bus.data_sram_addr_ok = resetn && (count_q < CntW'(MAX_OUT));
   assign push = bus.data_sram_req && bus.data_sram_addr_ok;
   assign pop  = resetn && (count_q != '0) && (dly_q[head_q] == 3'd0);

   assign bus.data_sram_data_ok = pop;
   assign bus.data_sram_rdata   = pop ? rd_q[head_q] : 32'h0;
   assign prot_err              = resetn && prot_err_q;

   assign rd_capture = bus.data_sram_wr ? 32'h0 : mem[idx];

   always_comb begin
      bad = 1'b0;
      unique case (bus.data_sram_size)
         2'd1:    bad = bus.data_sram_addr[0];
         2'd2:    bad = (bus.data_sram_addr[1:0] != 2'b00);
         2'd3:    bad = 1'b1;
         default: bad = 1'b0;
      endcase
      if (bus.data_sram_wr && (bus.data_sram_wstrb == 4'h0)) bad = 1'b1;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)  head_d = ptr_inc(head_q);
      if (push) tail_d = ptr_inc(tail_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         prot_err_q <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUT; i++) begin
            dly_q[i] <= 3'd0;
            rd_q[i]  <= 32'h0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         // Every slot counts down, so a waiting non-head entry is ready once it reaches the head.
         for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (dly_q[i] != 3'd0) dly_q[i] <= dly_q[i] - 3'd1;
         end
         if (push) begin
            dly_q[tail_q] <= DlyInit;
            rd_q[tail_q]  <= rd_capture;
            if (bad) prot_err_q <= 1'b1;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push && bus.data_sram_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dsram_like_responder.sv
// Three differently parameterised responders driven by one master stimulus and
// compared against a transaction-level model of memory, ordering and due cycles.
module tb_dsram_like_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;

   dsram_like_responder_if bus0 ();
   dsram_like_responder_if bus1 ();
   dsram_like_responder_if bus2 ();

   assign bus0.data_sram_req = req;    assign bus1.data_sram_req = req;
   assign bus2.data_sram_req = req;    assign bus0.data_sram_wr = wr;
   assign bus1.data_sram_wr = wr;      assign bus2.data_sram_wr = wr;
   assign bus0.data_sram_size = size;  assign bus1.data_sram_size = size;
   assign bus2.data_sram_size = size;  assign bus0.data_sram_addr = addr;
   assign bus1.data_sram_addr = addr;  assign bus2.data_sram_addr = addr;
   assign bus0.data_sram_wstrb = wstrb; assign bus1.data_sram_wstrb = wstrb;
   assign bus2.data_sram_wstrb = wstrb; assign bus0.data_sram_wdata = wdata;
   assign bus1.data_sram_wdata = wdata; assign bus2.data_sram_wdata = wdata;

   logic perr0, perr1, perr2;

   dsram_like_responder #(.IDX_W(8), .MAX_OUT(2), .RESP_DELAY(2)) dut0 (
      .clk(clk), .resetn(resetn), .bus(bus0), .prot_err(perr0));
   dsram_like_responder #(.IDX_W(8), .MAX_OUT(2), .RESP_DELAY(1)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1), .prot_err(perr1));
   dsram_like_responder #(.IDX_W(4), .MAX_OUT(4), .RESP_DELAY(5)) dut2 (
      .clk(clk), .resetn(resetn), .bus(bus2), .prot_err(perr2));

   logic        aok [3];
   logic        dok [3];
   logic        perr [3];
   logic [31:0] rdo [3];
   assign aok[0] = bus0.data_sram_addr_ok; assign aok[1] = bus1.data_sram_addr_ok;
   assign aok[2] = bus2.data_sram_addr_ok; assign dok[0] = bus0.data_sram_data_ok;
   assign dok[1] = bus1.data_sram_data_ok; assign dok[2] = bus2.data_sram_data_ok;
   assign rdo[0] = bus0.data_sram_rdata;   assign rdo[1] = bus1.data_sram_rdata;
   assign rdo[2] = bus2.data_sram_rdata;   assign perr[0] = perr0;
   assign perr[1] = perr1;                 assign perr[2] = perr2;

   function automatic int p_mo(int i); return (i == 2) ? 4 : 2; endfunction
   function automatic int p_dl(int i); return (i == 0) ? 2 : (i == 1) ? 1 : 5; endfunction
   function automatic int p_iw(int i); return (i == 2) ? 4 : 8; endfunction

   // Reference model: per-instance memory, byte-known map, and a ring of pending
   // responses each tagged with the cycle index in which it must answer.
   logic [31:0] mmem [3][256];
   bit   [3:0]  mkn  [3][256];
   int          q_due [3][8];
   logic [31:0] q_rd  [3][8];
   bit          q_kn  [3][8];
   int          q_hd [3];
   int          q_n  [3];
   bit          mperr [3];
   bit          eaok [3];
   bit          edok [3];
   int          k;
   int          n_cmp, n_bad;

   function automatic void chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d cycle %0d: got %h want %h", name, inst, k, act, exp);
      end
   endfunction

   function automatic bit is_bad();
      return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
             (size == 2'd2 && addr[1:0] != 2'b00) || (wr && wstrb == 4'h0);
   endfunction

   task automatic mid_check();
      #4;
      for (int i = 0; i < 3; i++) begin
         eaok[i] = resetn && (q_n[i] < p_mo(i));
         edok[i] = resetn && (q_n[i] > 0) && (q_due[i][q_hd[i]] == k);
         chk("addr_ok", i, 32'(aok[i]), 32'(eaok[i]));
         chk("data_ok", i, 32'(dok[i]), 32'(edok[i]));
         chk("prot_err", i, 32'(perr[i]), 32'(resetn && mperr[i]));
         if (!edok[i]) chk("rdata_idle", i, rdo[i], 32'h0);
         else if (q_kn[i][q_hd[i]]) chk("rdata", i, rdo[i], q_rd[i][q_hd[i]]);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (!resetn) begin
            q_n[i] = 0; q_hd[i] = 0; mperr[i] = 1'b0;
         end else begin
            if (edok[i]) begin q_hd[i] = (q_hd[i] + 1) % 8; q_n[i]--; end
            if (req && eaok[i]) begin
               int ix, slot, due;
               ix = int'(addr >> 2) & ((1 << p_iw(i)) - 1);
               if (is_bad()) mperr[i] = 1'b1;
               due = k + p_dl(i);
               if (q_n[i] > 0 && q_due[i][(q_hd[i] + q_n[i] - 1) % 8] + 1 > due)
                  due = q_due[i][(q_hd[i] + q_n[i] - 1) % 8] + 1;
               slot = (q_hd[i] + q_n[i]) % 8;
               q_due[i][slot] = due;
               if (wr) begin
                  q_rd[i][slot] = 32'h0;
                  q_kn[i][slot] = 1'b1;
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb[b]) begin
                        mmem[i][ix][8*b +: 8] = wdata[8*b +: 8];
                        mkn[i][ix][b] = 1'b1;
                     end
                  end
               end else begin
                  q_rd[i][slot] = mmem[i][ix];
                  q_kn[i][slot] = (mkn[i][ix] == 4'hF);
               end
               q_n[i]++;
            end
         end
      end
      k++;
      #1;
   endtask

   task automatic drive(bit rq, bit w, logic [1:0] sz, logic [31:0] a, logic [3:0] st,
                        logic [31:0] d);
      req = rq; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
   endtask

   task automatic idle(int n);
      drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
      repeat (n) begin mid_check(); edge_step(); end
   endtask

   typedef struct {
      logic rq; logic w; logic [1:0] sz; logic [31:0] a; logic [3:0] st; logic [31:0] d;
      logic ea; logic ed; logic [31:0] er;
   } vec_t;

   function automatic vec_t v(logic rq, logic w, logic [1:0] sz, logic [31:0] a,
                              logic [3:0] st, logic [31:0] d, logic ea, logic ed,
                              logic [31:0] er);
      return '{rq, w, sz, a, st, d, ea, ed, er};
   endfunction

   vec_t vt [20];
   int   cnt;
   logic [31:0] got;

   initial begin
      k = 0; n_cmp = 0; n_bad = 0;
      for (int i = 0; i < 3; i++) begin q_n[i] = 0; q_hd[i] = 0; mperr[i] = 1'b0; end
      // Expected addr_ok/data_ok/rdata for the MAX_OUT=2, RESP_DELAY=2 instance.
      vt[0]  = v(1, 1, 2, 32'h10, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0);
      vt[1]  = v(1, 0, 2, 32'h10, 4'h0, 32'h0,        1, 0, 32'h0);
      vt[2]  = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        0, 1, 32'h0);
      vt[3]  = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 1, 32'hDEADBEEF);
      vt[4]  = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 0, 32'h0);
      vt[5]  = v(1, 1, 2, 32'h20, 4'hF, 32'h11223344, 1, 0, 32'h0);
      vt[6]  = v(1, 1, 0, 32'h21, 4'h2, 32'h0000AA00, 1, 0, 32'h0);
      vt[7]  = v(1, 0, 2, 32'h20, 4'h0, 32'h0,        0, 1, 32'h0);
      vt[8]  = v(1, 0, 2, 32'h20, 4'h0, 32'h0,        1, 1, 32'h0);
      vt[9]  = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 0, 32'h0);
      vt[10] = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 1, 32'h1122AA44);
      vt[11] = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 0, 32'h0);
      vt[12] = v(1, 0, 2, 32'h10, 4'h0, 32'h0,        1, 0, 32'h0);
      vt[13] = v(1, 0, 2, 32'h20, 4'h0, 32'h0,        1, 0, 32'h0);
      vt[14] = v(1, 0, 2, 32'h10, 4'h0, 32'h0,        0, 1, 32'hDEADBEEF);
      vt[15] = v(1, 0, 2, 32'h10, 4'h0, 32'h0,        1, 1, 32'h1122AA44);
      vt[16] = v(1, 0, 2, 32'h20, 4'h0, 32'h0,        1, 0, 32'h0);
      vt[17] = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        0, 1, 32'hDEADBEEF);
      vt[18] = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 1, 32'h1122AA44);
      vt[19] = v(0, 0, 2, 32'h0,  4'h0, 32'h0,        1, 0, 32'h0);

      resetn = 1'b0;
      drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      repeat (3) begin mid_check(); edge_step(); end
      resetn = 1'b1;

      for (int j = 0; j < 20; j++) begin
         drive(vt[j].rq, vt[j].w, vt[j].sz, vt[j].a, vt[j].st, vt[j].d);
         mid_check();
         chk("vec_addr_ok", 0, 32'(aok[0]), 32'(vt[j].ea));
         chk("vec_data_ok", 0, 32'(dok[0]), 32'(vt[j].ed));
         chk("vec_rdata", 0, rdo[0], vt[j].er);
         edge_step();
      end

      // Back-to-back reads with RESP_DELAY=1: count stays at 1, addr_ok never drops.
      idle(12);
      for (int j = 0; j < 7; j++) begin
         drive(j < 6, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
         mid_check();
         chk("b2b_addr_ok", 1, 32'(aok[1]), 32'd1);
         chk("b2b_data_ok", 1, 32'(dok[1]), 32'(j >= 1));
         if (j >= 1) chk("b2b_rdata", 1, rdo[1], 32'hDEADBEEF);
         edge_step();
      end

      // Misaligned half-word: flag is sticky yet the request is still answered.
      idle(12);
      drive(1'b1, 1'b0, 2'd1, 32'h31, 4'h0, 32'h0);
      mid_check();
      chk("perr_before", 0, 32'(perr[0]), 32'd0);
      edge_step();
      drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
      cnt = 0;
      repeat (8) begin mid_check(); if (dok[0]) cnt++; edge_step(); end
      chk("perr_sticky", 0, 32'(perr[0]), 32'd1);
      chk("perr_answered", 0, 32'(cnt), 32'd1);

      // Reset with two reads outstanding.
      idle(12);
      drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
      repeat (2) begin mid_check(); edge_step(); end
      drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
      resetn = 1'b0;
      cnt = 0;
      repeat (2) begin mid_check(); if (dok[0]) cnt++; edge_step(); end
      resetn = 1'b1;
      mid_check();
      chk("rst_addr_ok", 0, 32'(aok[0]), 32'd1);
      chk("rst_perr", 0, 32'(perr[0]), 32'd0);
      if (dok[0]) cnt++;
      edge_step();
      repeat (6) begin mid_check(); if (dok[0]) cnt++; edge_step(); end
      chk("rst_no_data_ok", 0, 32'(cnt), 32'd0);
      drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
      mid_check(); edge_step();
      drive(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
      got = 32'h0; cnt = 0;
      repeat (6) begin mid_check(); if (dok[0]) begin got = rdo[0]; cnt++; end edge_step(); end
      chk("rst_mem_kept_cnt", 0, 32'(cnt), 32'd1);
      chk("rst_mem_kept", 0, got, 32'hDEADBEEF);

      // Randomised traffic, including aliasing addresses and occasional resets.
      for (int j = 0; j < 3000; j++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 15) << 2) | (($urandom % 2) << 10);
         if ($urandom % 8 == 0) a = a | ($urandom % 4);
         drive(($urandom % 3) != 0, $urandom % 2, ($urandom % 8 == 0) ? 2'($urandom % 4) : 2'd2,
               a, ($urandom % 10 == 0) ? 4'h0 : 4'($urandom), $urandom);
         resetn = ($urandom % 150) != 0;
         mid_check();
         edge_step();
      end
      resetn = 1'b1;
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
